// File: rtl/mc_cpu_pkg.sv
// Shared constants for the mc_cpu multi-cycle MIPS-I subset core:
// opcodes, R-type funct codes, ALU-control encodings and FSM state codes.
package mc_cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef logic [2:0] alu_op_t;
    localparam alu_op_t ALU_ADD = 3'd0;
    localparam alu_op_t ALU_SUB = 3'd1;
    localparam alu_op_t ALU_AND = 3'd2;
    localparam alu_op_t ALU_OR  = 3'd3;
    localparam alu_op_t ALU_SLT = 3'd4;

    typedef logic [2:0] state_t;
    localparam state_t ST_FETCH  = 3'd0;
    localparam state_t ST_DECODE = 3'd1;
    localparam state_t ST_EXEC   = 3'd2;
    localparam state_t ST_MEM    = 3'd3;
    localparam state_t ST_WB     = 3'd4;
    localparam state_t ST_BRANCH = 3'd5;
    localparam state_t ST_JUMP   = 3'd6;
    localparam state_t ST_HALT   = 3'd7;

    function automatic logic funct_known(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT);
    endfunction

    function automatic alu_op_t funct_to_alu(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_cpu_alu.sv
// Combinational 32-bit ALU for mc_cpu: wrap-around add/sub, and, or, signed slt,
// plus a zero flag that the branch state uses for the equality test.
module mc_cpu_alu
    import mc_cpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     op,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        case (op)
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: result = a + b;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/mc_cpu.sv
// Multi-cycle MIPS-I subset core sharing one memory port for fetch and data.
// Build option: define MC_CPU_BNE_EN to execute opcode 05 as bne; otherwise it is a NOP.
module mc_cpu
    import mc_cpu_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          NREGS    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic [31:0]       dbg_pc
);

    localparam int RW = $clog2(NREGS);

    state_t        state;
    logic [31:0]   pc, ir, reg_a, reg_b, imm, alu_out, mdr;
    logic [31:0]   regs [NREGS];
    logic [5:0]    opcode, funct;
    logic [RW-1:0] rs_idx, rt_idx, rd_idx;
    logic [31:0]   rf_a, rf_b;
    logic [31:0]   alu_b, alu_result;
    alu_op_t       alu_op;
    logic          alu_zero, branch_taken;
    logic          wb_en;
    logic [RW-1:0] wb_idx;
    logic [31:0]   wb_data;

    assign opcode = ir[31:26];
    assign funct  = ir[5:0];
    assign rs_idx = ir[21 +: RW];
    assign rt_idx = ir[16 +: RW];
    assign rd_idx = ir[11 +: RW];
    assign rf_a   = (rs_idx == '0) ? 32'd0 : regs[rs_idx];
    assign rf_b   = (rt_idx == '0) ? 32'd0 : regs[rt_idx];

    // The branch state reuses the ALU as a subtractor so the zero flag gives A==B.
    always_comb begin
        alu_b  = reg_b;
        alu_op = ALU_ADD;
        if (state == ST_BRANCH) begin
            alu_op = ALU_SUB;
        end else if (opcode == OP_RTYPE) begin
            alu_op = funct_to_alu(funct);
        end else begin
            alu_b = imm;
        end
    end

    mc_cpu_alu u_alu (
        .a      (reg_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

`ifdef MC_CPU_BNE_EN
    assign branch_taken = (opcode == OP_BNE) ? !alu_zero : alu_zero;
`else
    assign branch_taken = alu_zero;
`endif

    always_comb begin
        wb_en   = 1'b0;
        wb_idx  = rt_idx;
        wb_data = alu_out;
        if (state == ST_WB) begin
            case (opcode)
                OP_RTYPE: begin
                    wb_en  = 1'b1;
                    wb_idx = rd_idx;
                end
                OP_ADDI: wb_en = 1'b1;
                OP_LW: begin
                    wb_en   = 1'b1;
                    wb_data = mdr;
                end
                default: wb_en = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            reg_a   <= '0;
            reg_b   <= '0;
            imm     <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wb_en && (wb_idx != '0)) begin
                regs[wb_idx] <= wb_data;
            end
            case (state)
                ST_FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata;
                        pc    <= pc + 32'd4;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    reg_a <= rf_a;
                    reg_b <= rf_b;
                    imm   <= {{16{ir[15]}}, ir[15:0]};
                    case (opcode)
                        OP_RTYPE:               state <= funct_known(funct) ? ST_EXEC : ST_FETCH;
                        OP_ADDI, OP_LW, OP_SW:  state <= ST_EXEC;
                        OP_BEQ:                 state <= ST_BRANCH;
`ifdef MC_CPU_BNE_EN
                        OP_BNE:                 state <= ST_BRANCH;
`else
                        OP_BNE:                 state <= ST_FETCH;
`endif
                        OP_J:                   state <= ST_JUMP;
                        OP_HALT:                state <= ST_HALT;
                        default:                state <= ST_FETCH;
                    endcase
                end
                ST_EXEC: begin
                    alu_out <= alu_result;
                    state   <= ((opcode == OP_LW) || (opcode == OP_SW)) ? ST_MEM : ST_WB;
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        if (opcode == OP_LW) begin
                            mdr   <= mem_rdata;
                            state <= ST_WB;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_WB:     state <= ST_FETCH;
                ST_BRANCH: begin
                    if (branch_taken) begin
                        pc <= pc + {imm[29:0], 2'b00};
                    end
                    state <= ST_FETCH;
                end
                ST_JUMP: begin
                    pc    <= {pc[31:28], ir[25:0], 2'b00};
                    state <= ST_FETCH;
                end
                ST_HALT:   state <= ST_HALT;
                default:   state <= ST_FETCH;
            endcase
        end
    end

    // Gating with rst_n makes an in-flight access vanish the moment reset asserts.
    assign mem_req   = rst_n && ((state == ST_FETCH) || (state == ST_MEM));
    assign mem_we    = rst_n && (state == ST_MEM) && (opcode == OP_SW);
    assign mem_addr  = {((state == ST_MEM) ? alu_out[ADDR_W-1:2] : pc[ADDR_W-1:2]), 2'b00};
    assign mem_wdata = reg_b;
    assign halted    = (state == ST_HALT);
    assign dbg_pc    = pc;

endmodule

// File: tb/tb_mc_cpu.sv
// Self-checking bench for mc_cpu: an instruction-level model predicts every cycle's bus
// outputs and dbg_pc; directed programs pin the model with literal results.
module tb_mc_cpu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata, dbg_pc;

    logic [31:0] mem   [64];
    logic [31:0] prog  [64];
    logic [31:0] mmem  [64];
    logic [31:0] mregs [32];
    logic [31:0] mpc;
    int          tests, fails, cyc;
    int          fw_lo, fw_hi, dw_lo, dw_hi;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    mc_cpu #(.ADDR_W(8), .RESET_PC(32'h0), .NREGS(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .halted    (halted),
        .dbg_pc    (dbg_pc)
    );

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] im);
        return {op, 5'(rs), 5'(rt), im};
    endfunction

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_j(input int idx);
        return {6'h02, 26'(idx)};
    endfunction

    task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic check_output(input string name, input logic ereq, input logic ewe, input logic [7:0] eaddr,
                                input logic [31:0] ewdata, input logic [31:0] epc, input logic ehalt);
        logic ok;
        ok = (mem_req === ereq) && (halted === ehalt) && (dbg_pc === epc);
        if (ereq) ok = ok && (mem_we === ewe) && (mem_addr === eaddr);
        if (ereq && ewe) ok = ok && (mem_wdata === ewdata);
        tests++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL %s cyc=%0d: got req=%b we=%b addr=%h wdata=%h pc=%h halt=%b, expected req=%b we=%b addr=%h wdata=%h pc=%h halt=%b",
                     name, cyc, mem_req, mem_we, mem_addr, mem_wdata, dbg_pc, halted,
                     ereq, ewe, eaddr, ewdata, epc, ehalt);
        end
    endtask

    // One clock cycle: check outputs mid-cycle, drive ready for the coming edge, commit stores.
    task automatic apply_stimulus(input string name, input logic ereq, input logic ewe, input logic [7:0] eaddr,
                                  input logic [31:0] ewdata, input logic [31:0] epc, input logic ehalt, input logic rdy);
        logic        wr;
        logic [7:0]  wa;
        logic [31:0] wd;
        check_output(name, ereq, ewe, eaddr, ewdata, epc, ehalt);
        wr = rdy && mem_req && mem_we;
        wa = mem_addr;
        wd = mem_wdata;
        mem_ready = rdy;
        @(posedge clk);
        #1;
        if (wr) mem[wa[7:2]] = wd;
        @(negedge clk);
        cyc++;
    endtask

    task automatic mem_phase(input string name, input logic we, input logic [7:0] addr,
                             input logic [31:0] wdata, input logic [31:0] pc, input int nwait);
        for (int w = 0; w <= nwait; w++)
            apply_stimulus(name, 1'b1, we, addr, wdata, pc, 1'b0, (w == nwait));
    endtask

    task automatic idle(input string name, input int n, input logic [31:0] pc, input logic hlt);
        repeat (n) apply_stimulus(name, 1'b0, 1'b0, 8'h00, 32'h0, pc, hlt, 1'($urandom_range(0, 1)));
    endtask

    task automatic set_reg(input logic [4:0] idx, input logic [31:0] val);
        if (idx != 5'd0) mregs[idx] = val;
    endtask

    // Architectural step of one instruction, expanding it into its expected bus cycles.
    task automatic exec_one(output bit done);
        logic [31:0] instr, pc4, npc, a, b, im, ea, res;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        done  = 1'b0;
        instr = mmem[mpc[7:2]];
        mem_phase("fetch", 1'b0, {mpc[7:2], 2'b00}, 32'h0, mpc, $urandom_range(fw_hi, fw_lo));
        pc4 = mpc + 32'd4;
        npc = pc4;
        op  = instr[31:26];
        fn  = instr[5:0];
        rs  = instr[25:21];
        rt  = instr[20:16];
        rd  = instr[15:11];
        a   = mregs[rs];
        b   = mregs[rt];
        im  = {{16{instr[15]}}, instr[15:0]};
        ea  = a + im;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: begin
                        case (fn)
                            6'h20:   res = a + b;
                            6'h22:   res = a - b;
                            6'h24:   res = a & b;
                            6'h25:   res = a | b;
                            default: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        endcase
                        idle("rtype", 3, pc4, 1'b0);
                        set_reg(rd, res);
                    end
                    default: idle("nop_funct", 1, pc4, 1'b0);
                endcase
            end
            6'h08: begin
                idle("addi", 3, pc4, 1'b0);
                set_reg(rt, ea);
            end
            6'h23: begin
                idle("lw", 2, pc4, 1'b0);
                mem_phase("lw_mem", 1'b0, {ea[7:2], 2'b00}, 32'h0, pc4, $urandom_range(dw_hi, dw_lo));
                idle("lw_wb", 1, pc4, 1'b0);
                set_reg(rt, mmem[ea[7:2]]);
            end
            6'h2B: begin
                idle("sw", 2, pc4, 1'b0);
                mem_phase("sw_mem", 1'b1, {ea[7:2], 2'b00}, b, pc4, $urandom_range(dw_hi, dw_lo));
                mmem[ea[7:2]] = b;
            end
            6'h04: begin
                idle("beq", 2, pc4, 1'b0);
                if (a == b) npc = pc4 + (im << 2);
            end
`ifdef MC_CPU_BNE_EN
            6'h05: begin
                idle("bne", 2, pc4, 1'b0);
                if (a != b) npc = pc4 + (im << 2);
            end
`endif
            6'h02: begin
                idle("j", 2, pc4, 1'b0);
                npc = {pc4[31:28], instr[25:0], 2'b00};
            end
            6'h3F: begin
                idle("halt_dec", 1, pc4, 1'b0);
                idle("halted", 6, pc4, 1'b1);
                done = 1'b1;
            end
            default: idle("nop_op", 1, pc4, 1'b0);
        endcase
        mpc = npc;
    endtask

    task automatic run_program(input int max_instr);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_instr && !done; i++) exec_one(done);
    endtask

    task automatic load_program();
        for (int i = 0; i < 64; i++) begin
            mem[i]  = prog[i];
            mmem[i] = prog[i];
        end
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || halted !== 1'b0 || dbg_pc !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset: got req=%b we=%b halt=%b pc=%h, expected 0 0 0 00000000",
                     mem_req, mem_we, halted, dbg_pc);
        end
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        mpc = 32'h0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        cyc = 0;
    endtask

    task automatic clear_program();
        for (int i = 0; i < 64; i++) prog[i] = (i < 32) ? 32'hFC000000 : 32'hA5A5A5A5;
    endtask

    function automatic logic [31:0] rand_instr();
        int          kind, rs, rt, rd;
        logic [5:0]  fn;
        kind = $urandom_range(0, 11);
        rs   = $urandom_range(0, 7);
        rt   = $urandom_range(0, 7);
        rd   = $urandom_range(0, 7);
        case ($urandom_range(0, 5))
            0: fn = 6'h20;
            1: fn = 6'h22;
            2: fn = 6'h24;
            3: fn = 6'h25;
            4: fn = 6'h2A;
            default: fn = 6'h21;
        endcase
        case (kind)
            0, 1, 2, 3: return enc_r(rs, rt, rd, fn);
            4, 5:       return enc_i(6'h08, rs, rt, 16'($urandom));
            6, 7:       return enc_i((kind == 6) ? 6'h23 : 6'h2B, ($urandom_range(0, 3) == 0) ? rs : 0, rt,
                                     16'(32'h80 + 4 * $urandom_range(0, 31)));
            8:          return enc_i(6'h04, rs, rt, 16'($urandom_range(0, 8) - 4));
            9:          return enc_i(6'h05, rs, rt, 16'($urandom_range(0, 8) - 4));
            10:         return enc_j($urandom_range(0, 31));
            default:    return ($urandom_range(0, 7) == 0) ? 32'hFC000000 : enc_i(6'h3E, rs, rt, 16'h0);
        endcase
    endfunction

    initial begin
        #5_000_000;
        fails++;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        bit done;
        int c0;
        tests     = 0;
        fails     = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        mem_ready = 1'b0;

        // Directed program: ALU ops, r0 protection, load/store, beq, j, bne, halt.
        clear_program();
        prog[0]  = enc_i(6'h08, 0, 1, 16'd5);
        prog[1]  = enc_i(6'h2B, 0, 1, 16'h80);
        prog[2]  = enc_i(6'h08, 0, 1, 16'd7);
        prog[3]  = enc_i(6'h08, 0, 2, 16'hFFFF);
        prog[4]  = enc_r(1, 2, 3, 6'h20);
        prog[5]  = enc_r(1, 2, 0, 6'h22);
        prog[6]  = enc_i(6'h2B, 0, 3, 16'h84);
        prog[7]  = enc_i(6'h2B, 0, 0, 16'h88);
        prog[8]  = enc_r(2, 1, 5, 6'h2A);
        prog[9]  = enc_i(6'h2B, 0, 5, 16'h8C);
        prog[10] = enc_i(6'h23, 0, 4, 16'h84);
        prog[11] = enc_i(6'h04, 4, 3, 16'd1);
        prog[12] = enc_i(6'h08, 0, 4, 16'd99);
        prog[13] = enc_i(6'h2B, 0, 4, 16'h90);
        prog[14] = enc_j(32'h10);
        prog[15] = enc_i(6'h08, 0, 6, 16'd77);
        prog[16] = enc_i(6'h05, 1, 2, 16'd1);
        prog[17] = enc_i(6'h08, 0, 6, 16'd1);
        prog[18] = enc_i(6'h2B, 0, 6, 16'h94);
        prog[19] = enc_r(3, 1, 7, 6'h24);
        prog[20] = enc_r(7, 5, 8, 6'h25);
        prog[21] = enc_i(6'h2B, 0, 8, 16'h98);
        prog[22] = 32'hFC000000;
        prog[34] = 32'h0000DEAD;
        load_program();
        fw_lo = 0; fw_hi = 0; dw_lo = 0; dw_hi = 0;
        apply_reset();
        exec_one(done);
        check_value("addi_cycles", cyc, 32'd4);
        check_value("addi_pc", dbg_pc, 32'h4);
        run_program(40);
        check_value("sw_r1_5", mem[32], 32'd5);
        check_value("add_wrap", mem[33], 32'd6);
        check_value("r0_stays_0", mem[34], 32'd0);
        check_value("slt_signed", mem[35], 32'd1);
        check_value("lw_beq_taken", mem[36], 32'd6);
`ifdef MC_CPU_BNE_EN
        check_value("bne_opcode05", mem[37], 32'd0);
`else
        check_value("bne_opcode05", mem[37], 32'd1);
`endif
        check_value("and_or", mem[38], 32'd7);
        check_value("halt_pc", dbg_pc, 32'h5C);

        // Store then load with two data wait states each.
        clear_program();
        prog[0] = enc_i(6'h08, 0, 1, 16'h1234);
        prog[1] = enc_i(6'h2B, 0, 1, 16'h88);
        prog[2] = enc_i(6'h23, 0, 4, 16'h88);
        prog[3] = enc_i(6'h2B, 0, 4, 16'h8C);
        load_program();
        fw_lo = 0; fw_hi = 0; dw_lo = 2; dw_hi = 2;
        apply_reset();
        exec_one(done);
        c0 = cyc;
        exec_one(done);
        check_value("sw_wait_cycles", cyc - c0, 32'd6);
        c0 = cyc;
        exec_one(done);
        check_value("lw_wait_cycles", cyc - c0, 32'd7);
        run_program(10);
        check_value("lw_equals_sw", mem[35], 32'h1234);

        // beq to itself at 0x10, reached through NOPs (unknown opcode and funct).
        clear_program();
        prog[0] = enc_i(6'h08, 0, 1, 16'd3);
        prog[1] = enc_i(6'h3E, 0, 0, 16'h0);
        prog[2] = enc_r(1, 1, 9, 6'h21);
        prog[3] = enc_i(6'h3E, 1, 2, 16'h0);
        prog[4] = enc_i(6'h04, 1, 1, 16'hFFFF);
        load_program();
        fw_lo = 0; fw_hi = 0; dw_lo = 0; dw_hi = 0;
        apply_reset();
        for (int i = 0; i < 4; i++) exec_one(done);
        c0 = cyc;
        exec_one(done);
        check_value("beq_cycles", cyc - c0, 32'd3);
        check_value("beq_self_pc", dbg_pc, 32'h10);
        exec_one(done);

        // Jump beyond the 8-bit address space: dbg_pc is full width, mem_addr truncates.
        clear_program();
        prog[0] = enc_j(32'h40);
        load_program();
        apply_reset();
        exec_one(done);
        check_value("j_pc", dbg_pc, 32'h100);
        check_value("j_addr_trunc", {24'h0, mem_addr}, 32'h0);
        exec_one(done);

        // Reset asserted in the middle of a waiting store aborts it.
        clear_program();
        prog[0]  = enc_i(6'h08, 0, 1, 16'h11);
        prog[1]  = enc_i(6'h2B, 0, 1, 16'h80);
        prog[32] = 32'h0000CAFE;
        load_program();
        apply_reset();
        exec_one(done);
        mem_phase("fetch", 1'b0, 8'h04, 32'h0, 32'h4, 0);
        idle("sw", 2, 32'h8, 1'b0);
        apply_stimulus("sw_wait", 1'b1, 1'b1, 8'h80, 32'h11, 32'h8, 1'b0, 1'b0);
        apply_stimulus("sw_wait", 1'b1, 1'b1, 8'h80, 32'h11, 32'h8, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_value("abort_req", {31'h0, mem_req}, 32'h0);
        check_value("abort_pc", dbg_pc, 32'h0);
        @(posedge clk);
        #1;
        check_value("abort_no_store", mem[32], 32'h0000CAFE);
        apply_reset();
        run_program(10);
        check_value("store_after_reset", mem[32], 32'h11);

        // Random programs with random fetch and data wait states.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 64; i++) prog[i] = (i < 32) ? rand_instr() : $urandom;
            load_program();
            fw_lo = 0; fw_hi = 2; dw_lo = 0; dw_hi = 3;
            apply_reset();
            run_program(150);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mc_cpu.md
MC_CPU -- requirements
Module: mc_cpu

Interface
REQ-001 SHALL have parameter ADDR_W, 8, byte-address bits driven on mem_addr (min 4, max 32).
REQ-002 SHALL have parameter RESET_PC, 32'h0, PC value loaded at reset.
REQ-003 SHALL have parameter NREGS, 32, register-file depth (power of 2, 8..32); register specifiers index modulo NREGS.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port mem_req  output  1  memory access request.
REQ-007 SHALL have port mem_we  output  1  1=write, 0=read; valid while mem_req.
REQ-008 SHALL have port mem_addr  output  ADDR_W  word-aligned byte address; low 2 bits always 0.
REQ-009 SHALL have port mem_wdata  output  32  store data; valid while mem_req&&mem_we.
REQ-010 SHALL have port mem_rdata  input  32  read data; sampled when mem_ready.
REQ-011 SHALL have port mem_ready  input  1  access completes on the posedge where mem_req&&mem_ready.
REQ-012 SHALL have port halted  output  1  core stopped on HALT opcode.
REQ-013 SHALL have port dbg_pc  output  32  current PC register.

Function
REQ-014 SHALL execute MIPS-I subset: R-type add/sub/and/or/slt (funct 20/22/24/25/2A), lw(23), sw(2B), beq(04), addi(08), j(02), HALT(3F).
REQ-015 SHALL implement FSM FETCH->DECODE->{EXEC->(MEM)->WB | BRANCH | JUMP | HALT}; one state per cycle except FETCH/MEM.
REQ-016 FETCH SHALL drive mem_req=1, mem_we=0, mem_addr=PC, hold them stable until mem_ready; on mem_ready latch IR<=mem_rdata, PC<=PC+4, go DECODE.
REQ-017 DECODE SHALL latch A<=R[rs], B<=R[rt], sign-extended imm; dispatch by opcode.
REQ-018 EXEC SHALL compute ALU result into ALUOut (add for lw/sw/addi); lw/sw go MEM, others go WB.
REQ-019 MEM SHALL drive mem_req=1, mem_addr=ALUOut, mem_we=(sw), mem_wdata=B until mem_ready; lw latches MDR and goes WB; sw goes FETCH.
REQ-020 WB SHALL write rd (R-type), rt (addi), or MDR to rt (lw); then FETCH.
REQ-021 BRANCH SHALL set PC<=PC+(imm<<2) when A==B, else keep PC; then FETCH.
REQ-022 JUMP SHALL set PC<={PC[31:28],IR[25:0],2'b00}; then FETCH.
REQ-023 Register 0 SHALL read 0; writes to register 0 SHALL be discarded.
REQ-024 Unknown opcode or funct SHALL act as NOP (FETCH next, PC already +4).
REQ-025 HALT state SHALL be terminal: halted=1, mem_req=0, no state change until reset.
REQ-026 mem_req SHALL be 0 in DECODE/EXEC/WB/BRANCH/JUMP; cycle counts with zero-wait memory: R/addi 4, lw 5, sw 4, beq/j 3; each wait cycle adds 1.
REQ-027 Arithmetic SHALL be 32-bit wrap-around, no overflow trap; slt signed; PC wraps modulo 2^32, mem_addr = PC/ALUOut[ADDR_W-1:0] with [1:0] forced 0.

Reset
REQ-028 While rst_n=0: state=FETCH, PC=RESET_PC, IR/A/B/ALUOut/MDR=0, all registers 0, mem_req=0, mem_we=0, halted=0.
REQ-029 Reset assertion mid-access SHALL abort it immediately; mem_req drops asynchronously; the first FETCH begins on the first posedge after release.

Configuration
REQ-030 Macro MC_CPU_BNE_EN defined: opcode 05 (bne) SHALL branch when A!=B, 3 cycles; undefined: opcode 05 SHALL be a NOP per REQ-024.

Structure
REQ-031 Package mc_cpu_pkg SHALL hold opcode/funct constants, the state enum, and ALU-control encodings.
REQ-032 Combinational ALU SHALL be sub-module mc_cpu_alu (32-bit a, b, op -> result, zero).

Verification
REQ-033 Reset, zero-wait: addi $1,$0,5 at 0 -> R1=5 after 4 cycles; dbg_pc=4.
REQ-034 add $3,$1,$2 with R1=7,R2=FFFFFFFF -> R3=6; sub $0,$1,$2 -> R0 stays 0.
REQ-035 sw $1,8($0) then lw $4,8($0), mem_ready delayed 2 cycles each -> mem_addr/wdata stable during wait, R4=R1, sw 6 and lw 7 cycles.
REQ-036 beq $1,$1,-1 at PC=0x10 -> PC=0x10 after 3 cycles; j 0x40 -> PC=0x100.
REQ-037 HALT at PC=0x20 -> halted=1, mem_req=0 forever; rst_n pulse mid-MEM -> mem_req=0 at once, PC=RESET_PC.
REQ-038 opcode 05 with A!=B: with MC_CPU_BNE_EN branch taken; without it PC=PC+4.
